// File: rtl/alu_result_fifo_if.sv
// Bundle of the ALU result capture stage: ALU-side inputs and the
// inspection-side outputs. The master drives the ALU result and requests
// and observes the FIFO. The slave is the FIFO itself.
interface alu_result_fifo_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
);
    logic [3:0]  res_in;
    logic        cout_in;
    logic        capture;
    logic        pop;
    logic [4:0]  q;
    logic [AW:0] count;
    logic        empty;
    logic        full;
    logic [7:0]  acc;
    logic        ovf;
    logic        udf;

    modport master (
        output res_in, cout_in, capture, pop,
        input  q, count, empty, full, acc, ovf, udf
    );

    modport slave (
        input  res_in, cout_in, capture, pop,
        output q, count, empty, full, acc, ovf, udf
    );
endinterface

// File: rtl/alu_result_fifo.sv
// Capture stage behind the 4-bit ALU.
// A rising edge on capture pushes {cout,res} into a show-ahead FIFO.
// A rising edge on pop steps to the next entry.
// The block also keeps a mod-256 running sum of the accepted words and
// sticky overflow/underflow flags.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    alu_result_fifo_if.slave  bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [4:0]    mem_q [DEPTH];
    logic [4:0]    mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          cap_prev_q, cap_prev_d;
    logic          pop_prev_q, pop_prev_d;

    logic          push_ev_s, pop_ev_s;
    logic          empty_s, full_s;
    logic          push_ok_s, pop_ok_s;
    logic [4:0]    wdata_s;
    logic [4:0]    q_s;

    // Edge events and acceptance. A push into a full FIFO is allowed when a pop
    // frees the head slot on the same edge.
    always_comb begin
        wdata_s   = {bus.cout_in, bus.res_in};
        push_ev_s = bus.capture & ~cap_prev_q;
        pop_ev_s  = bus.pop & ~pop_prev_q;
        empty_s   = (count_q == {(AW+1){1'b0}});
        full_s    = (count_q == FULL_CNT);
        push_ok_s = push_ev_s & (~full_s | pop_ev_s);
        pop_ok_s  = pop_ev_s & ~empty_s;
    end

    // Next-state computation for the pointers, storage, count, sum and flags.
    always_comb begin
        mem_d      = mem_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        acc_d      = acc_q;
        cap_prev_d = bus.capture;
        pop_prev_d = bus.pop;
        ovf_d      = ovf_q | (push_ev_s & full_s & ~pop_ev_s);
        udf_d      = udf_q | (pop_ev_s & empty_s);

        if (push_ok_s) begin
            mem_d[wp_q] = wdata_s;
            wp_d        = wp_q + AW'(1);
            acc_d       = acc_q + {3'b000, wdata_s};
        end else begin
            wp_d  = wp_q;
            acc_d = acc_q;
        end

        if (pop_ok_s) begin
            rp_d = rp_q + AW'(1);
        end else begin
            rp_d = rp_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            acc_q      <= 8'h00;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            cap_prev_q <= 1'b0;
            pop_prev_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            cap_prev_q <= cap_prev_d;
            pop_prev_q <= pop_prev_d;
        end
    end

    // Storage array. It is not reset because its contents are masked by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Show-ahead head word. The output reads 0 while nothing is held.
    always_comb begin
        if (empty_s) begin
            q_s = 5'd0;
        end else begin
            q_s = mem_q[rp_q];
        end
    end

    assign bus.q     = q_s;
    assign bus.count = count_q;
    assign bus.empty = empty_s;
    assign bus.full  = full_s;
    assign bus.acc   = acc_q;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
endmodule
